// File: rtl/sda_kernel_control_regs.sv
// AXI4-Lite control registers for the SDAccel kernel wrapper.
// Drives the go/done handshake toward the reset handler.
module sda_kernel_control_regs #(
    parameter int AddrWidth = 8,
    parameter int NumArgs   = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [AddrWidth-1:0]    s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [AddrWidth-1:0]    s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    regGoValid,
    input  logic                    regGoHoldoff,
    input  logic                    regDoneValid,
    output logic                    regDoneStop,
    output logic [32*NumArgs-1:0]   kernelArgs,
    output logic                    irq
);

    localparam int IW = AddrWidth - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        gie_q, gie_d;
    logic        ier_q, ier_d;
    logic        isr_q, isr_d;
    logic        irq_q, irq_d;
    logic        go_valid_q, go_valid_d;
    logic        done_stop_q, done_stop_d;
    logic [31:0] args_q [NumArgs];
    logic [31:0] args_d [NumArgs];

    logic          wr_fire, rd_fire;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          wr_ctrl, wr_gie, wr_ier, wr_isr;
    logic          start_req, go_acc, done_acc;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    // A write needs both AW and W together and no response pending.
    assign wr_fire   = s_awvalid & s_wvalid & ~bvalid_q & ~srst;
    assign rd_fire   = s_arvalid & ~rvalid_q & ~srst;
    assign s_awready = wr_fire;
    assign s_wready  = wr_fire;
    assign s_arready = rd_fire;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = 2'b00;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = 2'b00;

    assign wr_idx = s_awaddr[AddrWidth-1:2];
    assign rd_idx = s_araddr[AddrWidth-1:2];

    assign wr_ctrl = wr_fire & (wr_idx == IW'(0));
    assign wr_gie  = wr_fire & (wr_idx == IW'(1));
    assign wr_ier  = wr_fire & (wr_idx == IW'(2));
    assign wr_isr  = wr_fire & (wr_idx == IW'(3));

    assign start_req = wr_ctrl & s_wstrb[0] & s_wdata[0];
    assign go_acc    = go_valid_q & ~regGoHoldoff;
    assign done_acc  = regDoneValid & ~done_stop_q;

    assign regGoValid  = go_valid_q;
    assign regDoneStop = done_stop_q;
    assign irq         = irq_q;

    for (genvar g = 0; g < NumArgs; g++) begin : g_args
        assign kernelArgs[32*g +: 32] = args_q[g];
    end

    // Run-state sequencing; handshake outputs follow the next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_req) state_d = GO;
            GO:      if (go_acc)    state_d = RUN;
            RUN:     if (done_acc)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        go_valid_d  = (state_d == GO);
        done_stop_d = (state_d != RUN);
    end

    // Register file updates; done/ISR sets win over clears.
    always_comb begin
        gie_d = gie_q;
        if (wr_gie && s_wstrb[0]) gie_d = s_wdata[0];
        ier_d = ier_q;
        if (wr_ier && s_wstrb[0]) ier_d = s_wdata[0];
        isr_d = isr_q;
        if (wr_isr && s_wstrb[0] && s_wdata[0]) isr_d = ~isr_q;
        if (done_acc && ier_q) isr_d = 1'b1;
        done_d = done_q;
        if (rd_fire && rd_idx == IW'(0) && done_q) done_d = 1'b0;
        if (done_acc) done_d = 1'b1;
        irq_d = gie_q & isr_q;
        for (int n = 0; n < NumArgs; n++) begin
            args_d[n] = args_q[n];
            if (wr_fire && wr_idx == IW'(4 + n)) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wstrb[b]) args_d[n][8*b +: 8] = s_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read mux and AXI response channels.
    always_comb begin
        rd_word = 32'h0;
        if (rd_idx == IW'(0)) begin
            rd_word = {29'h0, state_q == IDLE, done_q, state_q != IDLE};
        end
        if (rd_idx == IW'(1)) rd_word = {31'h0, gie_q};
        if (rd_idx == IW'(2)) rd_word = {31'h0, ier_q};
        if (rd_idx == IW'(3)) rd_word = {31'h0, isr_q};
        for (int n = 0; n < NumArgs; n++) begin
            if (rd_idx == IW'(4 + n)) rd_word = args_q[n];
        end
        bvalid_d = bvalid_q;
        if (wr_fire) bvalid_d = 1'b1;
        else if (bvalid_q && s_bready) bvalid_d = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            gie_q       <= 1'b0;
            ier_q       <= 1'b0;
            isr_q       <= 1'b0;
            irq_q       <= 1'b0;
            go_valid_q  <= 1'b0;
            done_stop_q <= 1'b1;
            for (int n = 0; n < NumArgs; n++) args_q[n] <= 32'h0;
        end else begin
            state_q     <= state_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            gie_q       <= gie_d;
            ier_q       <= ier_d;
            isr_q       <= isr_d;
            irq_q       <= irq_d;
            go_valid_q  <= go_valid_d;
            done_stop_q <= done_stop_d;
            for (int n = 0; n < NumArgs; n++) args_q[n] <= args_d[n];
        end
    end

endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// Directed bench for sda_kernel_control_regs.
// Hand-computed register and handshake expectations.
module tb_sda_kernel_control_regs;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic [7:0]   s_awaddr = '0;
    logic         s_awvalid = 1'b0;
    logic         s_awready;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wstrb = '0;
    logic         s_wvalid = 1'b0;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready = 1'b0;
    logic [7:0]   s_araddr = '0;
    logic         s_arvalid = 1'b0;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready = 1'b0;
    logic         regGoValid;
    logic         regGoHoldoff = 1'b0;
    logic         regDoneValid = 1'b0;
    logic         regDoneStop;
    logic [127:0] kernelArgs;
    logic         irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sda_kernel_control_regs #(.AddrWidth(8), .NumArgs(4)) dut (
        .clk(clk), .srst(srst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regGoValid(regGoValid), .regGoHoldoff(regGoHoldoff),
        .regDoneValid(regDoneValid), .regDoneStop(regDoneStop),
        .kernelArgs(kernelArgs), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int n;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        n = 0;
        #1;
        while (!s_awready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("aw_timeout", 32'(n), 32'd0);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        if (n >= 20) chk("b_timeout", 32'(n), 32'd0);
        chk("bresp", 32'(s_bresp), 32'd0);
        tick();
    endtask

    task automatic axi_rd(input logic [7:0] a, output logic [31:0] d);
        int n;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        #1;
        while (!s_arready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("ar_timeout", 32'(n), 32'd0);
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin tick(); n++; end
        if (n >= 20) chk("r_timeout", 32'(n), 32'd0);
        d = s_rdata;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        axi_rd(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        int bad;
        int acc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_go", 32'(regGoValid), 32'd0);
        chk("rst_stop", 32'(regDoneStop), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bv", 32'(s_bvalid), 32'd0);
        chk("rst_rv", 32'(s_rvalid), 32'd0);
        chk("rst_args", 32'(|kernelArgs), 32'd0);
        srst = 1'b0;
        tick();

        axi_wr(8'h10, 32'hDEADBEEF, 4'b0011);
        rd_chk("arg0_strb", 8'h10, 32'h0000BEEF);
        chk("karg0", kernelArgs[31:0], 32'h0000BEEF);
        axi_wr(8'h14, 32'h12345678, 4'b1100);
        chk("karg1", kernelArgs[63:32], 32'h12340000);
        axi_wr(8'h40, 32'hFFFFFFFF, 4'hF);
        rd_chk("unmapped", 8'h40, 32'h0);
        rd_chk("ctrl_idle", 8'h00, 32'h4);

        axi_wr(8'h04, 32'h1, 4'h1);
        axi_wr(8'h08, 32'h1, 4'h1);
        rd_chk("gie", 8'h04, 32'h1);
        rd_chk("ier", 8'h08, 32'h1);

        regGoHoldoff = 1'b1;
        axi_wr(8'h00, 32'h1, 4'h1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!regGoValid) bad++;
            tick();
        end
        chk("go_held", 32'(bad), 32'd0);
        rd_chk("ctrl_go", 8'h00, 32'h1);
        chk("go_still", 32'(regGoValid), 32'd1);
        regGoHoldoff = 1'b0;
        tick();
        chk("go_drop", 32'(regGoValid), 32'd0);
        chk("run_stop", 32'(regDoneStop), 32'd0);
        rd_chk("ctrl_run", 8'h00, 32'h1);

        axi_wr(8'h00, 32'h1, 4'h1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (regGoValid) bad++;
            tick();
        end
        chk("no_rego", 32'(bad), 32'd0);
        chk("run_kept", 32'(regDoneStop), 32'd0);

        regDoneValid = 1'b1;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            if (regDoneValid && !regDoneStop) acc++;
            tick();
        end
        regDoneValid = 1'b0;
        chk("done_once", 32'(acc), 32'd1);
        chk("done_stop", 32'(regDoneStop), 32'd1);
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("ctrl_done", 8'h00, 32'h6);
        rd_chk("ctrl_cor", 8'h00, 32'h4);

        axi_wr(8'h0C, 32'h1, 4'h1);
        tick();
        chk("irq_clr", 32'(irq), 32'd0);
        rd_chk("isr_clr", 8'h0C, 32'h0);
        axi_wr(8'h0C, 32'h1, 4'h1);
        rd_chk("isr_tog", 8'h0C, 32'h1);
        chk("irq_tog", 32'(irq), 32'd1);
        axi_wr(8'h0C, 32'h1, 4'h1);
        tick();
        chk("irq_off", 32'(irq), 32'd0);

        s_bready = 1'b0;
        s_awaddr = 8'h18; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        chk("stall_aw", 32'(s_awready), 32'd1);
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_bvalid || s_awready || s_wready) bad++;
            tick();
        end
        chk("b_stall", 32'(bad), 32'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        tick();
        chk("b_done", 32'(s_bvalid), 32'd0);
        chk("karg2", kernelArgs[95:64], 32'hA5A5A5A5);

        s_rready = 1'b0;
        s_araddr = 8'h10; s_arvalid = 1'b1;
        #1;
        chk("stall_ar", 32'(s_arready), 32'd1);
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!s_rvalid || s_arready || s_rdata !== 32'h0000BEEF) bad++;
            tick();
        end
        chk("r_stall", 32'(bad), 32'd0);
        s_arvalid = 1'b0; s_rready = 1'b1;
        tick();
        chk("r_done", 32'(s_rvalid), 32'd0);

        axi_wr(8'h00, 32'h1, 4'h1);
        tick();
        chk("run2", 32'(regDoneStop), 32'd0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_go", 32'(regGoValid), 32'd0);
        chk("srst_stop", 32'(regDoneStop), 32'd1);
        rd_chk("srst_ctrl", 8'h00, 32'h4);
        rd_chk("srst_arg", 8'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
